// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// Purely combinational 1-bit full adder, reused once per clock by the controller.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full-adder cell, one bit per clock, LSB first.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request taken only while IDLE (busy or done high means
  // it is dropped, never queued); done is a one-cycle valid for sum/cout with no
  // backpressure, and sum/cout hold afterwards.

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_rb_load;
  logic             w_carry_load;
  logic             w_s;
  logic             w_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as "no borrow".
  assign w_rb_load    = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : cin;
`else
  assign w_rb_load    = b;
  assign w_carry_load = cin;
`endif

  serial_fa_cell u_fa (
    .x  (r_ra[0]),
    .y  (r_rb[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ra    <= a;
            r_rb    <= w_rb_load;
            r_carry <= w_carry_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_carry <= w_co;
          r_ra    <= r_ra >> 1;
          r_rb    <= r_rb >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          // Counter stops at the last bit so it never wraps for power-of-two widths.
          if (r_cnt == LAST_BIT) begin
            r_cout  <= w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W        = 8;
  localparam int MAX_WAIT = 4 * W + 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_drv;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_drv),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // Reference: plain integer arithmetic, {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    longint unsigned total;
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = W'(x - y);
      r[W]     = (x >= y);
    end else begin
      total = longint'(x) + longint'(y) + longint'(c);
      r     = (W+1)'(total);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: one transaction from IDLE, measures latency (edges from raising start to done)
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic s, output int lat, output int busy_n,
                       output logic [W-1:0] got_sum, output logic got_cout, output bit to);
    a = x; b = y; cin = c; sub_drv = s; start = 1'b1;
    lat = 0; busy_n = 0;
    tick();
    lat = 1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    while (!done && lat < MAX_WAIT) begin
      busy_n += int'(busy);
      tick();
      lat++;
    end
    busy_n += int'(busy);
    to       = !done;
    got_sum  = sum;
    got_cout = cout;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_drv = 1'b0;
    tick(); tick();
    n_tests++;
    if ({busy, done, sum, cout, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b st=%0d expected all 0",
               busy, done, sum, cout, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'hFF};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[3] = '{8'h10, 8'h00, 8'hFF};
    logic         ec[3] = '{1'b0, 1'b1, 1'b1};
    int lat, bn;
    logic [W-1:0] gs;
    logic gc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b0, lat, bn, gs, gc, to);
      n_tests++;
      if (to || lat != W + 1) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d (timeout=%0d) expected %0d", i, lat, to, W + 1);
      end
      n_tests++;
      if (bn != W) begin
        n_fail++;
        $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bn, W);
      end
      n_tests++;
      if (gs !== es[i] || gc !== ec[i]) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got sum=%h cout=%b expected sum=%h cout=%b",
                 i, gs, gc, es[i], ec[i]);
      end
      tick();
      n_tests++;
      if (done !== 1'b0 || sum !== es[i] || cout !== ec[i]) begin
        n_fail++;
        $display("FAIL dir_hold[%0d]: got done=%b sum=%h cout=%b expected 0 %h %b",
                 i, done, sum, cout, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_random;
    int lat, bn;
    logic [W-1:0] x, y, gs;
    logic c, s, gc;
    logic [W:0] e;
    bit to;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp_q.push_back(model(x, y, c, s));
      do_op(x, y, c, s, lat, bn, gs, gc, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || {gc, gs} !== e || lat != W + 1) begin
        n_fail++;
        $display("FAIL rand[%0d] a=%h b=%h c=%b s=%b: got %b_%h lat=%0d expected %b_%h lat=%0d",
                 i, x, y, c, s, gc, gs, lat, e[W], e[W-1:0], W + 1);
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic test_start_ignored;
    int n_done = 0;
    int busy_after = 0;
    logic [W-1:0] first_sum = '0;
    logic first_cout = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub_drv = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h55; b = 8'h55; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        if (n_done == 0) begin
          first_sum  = sum;
          first_cout = cout;
        end
        n_done++;
      end else if (n_done > 0) begin
        busy_after += int'(busy);
      end
      tick();
    end
    n_tests++;
    if (n_done != 1 || busy_after != 0) begin
      n_fail++;
      $display("FAIL start_ignored_count: got dones=%0d busy_after=%0d expected 1 0",
               n_done, busy_after);
    end
    n_tests++;
    if (first_sum !== 8'h46 || first_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_result: got sum=%h cout=%b expected 46 0", first_sum, first_cout);
    end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    int lat, bn;
    logic [W-1:0] gs;
    logic gc;
    bit to;
    a = 8'hFF; b = 8'h00; cin = 1'b0; sub_drv = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, sum, cout, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b st=%0d expected all 0",
               busy, done, sum, cout, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      tick();
      if (done || busy) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d busy/done samples expected 0", stray);
    end
    do_op(8'h3C, 8'h5A, 1'b1, 1'b0, lat, bn, gs, gc, to);
    n_tests++;
    if (to || gs !== 8'h97 || gc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got sum=%h cout=%b timeout=%0d expected 97 0", gs, gc, to);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int last_done = -1;
    int n_res = 0;
    logic prev_done = 1'b0;
    logic [W:0] e;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_drv = 1'b0;
    exp_q.push_back(model(a, b, cin, 1'b0));
    start = 1'b1;
    while (n_res < 5 && cyc < 10 * (W + 2)) begin
      tick();
      cyc++;
      if (done) begin
        n_tests++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL b2b_consecutive_done: got done high two cycles at cycle %0d", cyc);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if ({cout, sum} !== e) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %b_%h expected %b_%h", n_res, cout, sum, e[W], e[W-1:0]);
        end
        if (last_done >= 0) begin
          n_tests++;
          if (cyc - last_done != W + 2) begin
            n_fail++;
            $display("FAIL b2b_interval[%0d]: got %0d expected %0d", n_res, cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        n_res++;
        if (n_res < 5) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
          exp_q.push_back(model(a, b, cin, 1'b0));
        end else begin
          start = 1'b0;
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    n_tests++;
    if (n_res != 5 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, %0d pending expected 5 0", n_res, exp_q.size());
    end
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got busy=%b expected 0", busy);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat, bn;
    logic [W-1:0] gs;
    logic gc;
    bit to;
    do_op(8'h05, 8'h07, 1'b0, 1'b1, lat, bn, gs, gc, to);
    n_tests++;
    if (to || gs !== 8'hFE || gc !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got sum=%h cout=%b expected fe 0", gs, gc);
    end
    tick();
    do_op(8'h07, 8'h05, 1'b0, 1'b1, lat, bn, gs, gc, to);
    n_tests++;
    if (to || gs !== 8'h02 || gc !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_no_borrow: got sum=%h cout=%b expected 02 1", gs, gc);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
